// File: rtl/incr_chain_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : incr_chain_sched_if
// Brief    : Request/response bundle between clients and incr_chain_sched.
// Revision : 1.0
// ============================================================================
interface incr_chain_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic [ID_W-1:0]          resp_id;
    logic                     busy;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, busy
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/incr_chain_sched.sv
`default_nettype none
// ============================================================================
// Module   : incr_chain_sched
// Brief    : Round-robin shared +STAGES pipeline with credit-guarded in-order
//            response FIFO.
// Revision : 1.0
// ============================================================================
module incr_chain_sched #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int STAGES     = 20,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    incr_chain_sched_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [WIDTH-1:0] c_stages = WIDTH'(STAGES);
    localparam logic [CNT_W-1:0] c_depth  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] c_last   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [ID_W-1:0]  c_ptr_rst = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic              w_found;
    logic              w_can_accept;
    logic              w_accept;
    logic [ID_W-1:0]   w_grant_idx;
    logic [WIDTH-1:0]  w_grant_data;

    logic              w_push;
    logic [ID_W-1:0]   w_push_id;
    logic [WIDTH-1:0]  w_push_data;

    logic [WIDTH-1:0]  mem_data_q [FIFO_DEPTH];
    logic [ID_W-1:0]   mem_id_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  w_count_after_pop;
    logic              w_pop;
    logic              w_head_from_push;
    logic [WIDTH-1:0]  head_data_q;
    logic [ID_W-1:0]   head_id_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == c_last) ? '0 : p + PTR_W'(1);
    endfunction

    // Indices above the pointer win first, then the wrapped-around lower ones.
    always_comb begin
        w_found      = 1'b0;
        w_grant_idx  = '0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req_valid[i] && (i > int'(ptr_q))) begin
                w_found      = 1'b1;
                w_grant_idx  = ID_W'(i);
                w_grant_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req_valid[i] && (i <= int'(ptr_q))) begin
                w_found      = 1'b1;
                w_grant_idx  = ID_W'(i);
                w_grant_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_can_accept  = (outstanding_q < c_depth);
    assign w_accept      = w_can_accept & w_found;
    assign bus.req_ready = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign ptr_d         = w_accept ? w_grant_idx : ptr_q;

    // Stage 1..LAT-1 are registers; the value leaving stage LAT-1 is written
    // straight into the FIFO, which supplies the final cycle of latency.
    if (LAT > 1) begin : g_pipe
        logic [LAT-2:0]   vld_q;
        logic [ID_W-1:0]  id_q  [LAT-1];
        logic [WIDTH-1:0] dat_q [LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= w_accept;
                for (int k = 1; k < LAT - 1; k++) begin
                    vld_q[k] <= vld_q[k-1];
                end
            end
            id_q[0]  <= w_grant_idx;
            dat_q[0] <= w_grant_data + c_stages;
            for (int k = 1; k < LAT - 1; k++) begin
                id_q[k]  <= id_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
        end

        assign w_push      = vld_q[LAT-2];
        assign w_push_id   = id_q[LAT-2];
        assign w_push_data = dat_q[LAT-2];
    end else begin : g_direct
        assign w_push      = w_accept;
        assign w_push_id   = w_grant_idx;
        assign w_push_data = w_grant_data + c_stages;
    end

    always_comb begin
        w_pop             = (count_q != '0) & bus.resp_ready;
        rd_ptr_d          = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d          = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        w_count_after_pop = count_q - CNT_W'(w_pop);
        count_d           = w_count_after_pop + CNT_W'(w_push);
        w_head_from_push  = w_push & (w_count_after_pop == '0);
        outstanding_d     = outstanding_q + CNT_W'(w_accept) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_data_q[wr_ptr_q] <= w_push_data;
            mem_id_q[wr_ptr_q]   <= w_push_id;
        end
    end

    // Head registers only move when there is a next entry, so the outputs
    // keep showing the last response while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= c_ptr_rst;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            head_data_q   <= '0;
            head_id_q     <= '0;
        end else begin
            ptr_q         <= ptr_d;
            outstanding_q <= outstanding_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            if (count_d != '0) begin
                head_data_q <= w_head_from_push ? w_push_data : mem_data_q[rd_ptr_d];
                head_id_q   <= w_head_from_push ? w_push_id   : mem_id_q[rd_ptr_d];
            end
        end
    end

    assign bus.resp_valid = (count_q != '0);
    assign bus.resp_data  = head_data_q;
    assign bus.resp_id    = head_id_q;
    assign bus.busy       = (outstanding_q != '0);
endmodule
`default_nettype wire

// File: doc/incr_chain_sched.md
Name: incr_chain_sched

Overview:
- Shares one pipelined +STAGES increment datapath between NUM_REQ requesters.
- Round-robin arbitration on the request side, one accept per cycle.
- A fixed-latency internal pipeline computes in + STAGES; results go through an in-order response FIFO.
- A credit counter guarantees the FIFO never overflows, so the pipeline never stalls; sits between client blocks and the increment-chain function.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 8, operand/result width
- STAGES, 20, constant added to each operand (models the 20-deep +1 chain)
- LAT, 4, pipeline depth in cycles (>=1)
- FIFO_DEPTH, 8, response FIFO entries = max outstanding transactions (>=LAT recommended, >=1 required)
- ID_W, $clog2(NUM_REQ) (min 1), requester id width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
- req_data  input  NUM_REQ*WIDTH  operands, requester i at bits [i*WIDTH +: WIDTH]
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_data  output  WIDTH  (operand + STAGES) mod 2^WIDTH
- resp_id  output  ID_W  index of originating requester
- busy  output  1  outstanding count != 0

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - all pipeline valid bits 0; FIFO empty; outstanding=0; rr pointer = NUM_REQ-1, so requester 0 has top priority first.
  - Outputs after reset: req_ready=0, resp_valid=0, resp_data=0, resp_id=0, busy=0.
  - Reset mid-operation discards all in-flight and queued transactions; no response is produced for them.
- Credit: can_accept = (outstanding < FIFO_DEPTH).
- Arbitration (combinational):
  - If can_accept, grant the first i with req_valid[i], scanning from pointer+1 upward with wrap.
  - req_ready = one-hot grant, else all 0. req_ready may depend on req_valid.
  - Accept = req_valid[i] & req_ready[i].
  - On accept, pointer <= granted index; otherwise the pointer holds.
- Handshake rule: requesters hold req_valid and req_data stable until accepted. A deasserted valid is not an error; it simply is not granted.
- Pipeline:
  - Accept in cycle t loads stage 1 {valid, id, req_data+STAGES} at the end of t.
  - Stages shift unconditionally every cycle; stage LAT content is pushed into the FIFO at the end of cycle t+LAT-1.
  - The addition is truncated to WIDTH bits (wraps; no carry out).
- Response FIFO:
  - Registered head; resp_valid = !empty; resp_data/resp_id = head entry; pop = resp_valid & resp_ready.
  - Minimum latency: accept in cycle t gives resp_valid in cycle t+LAT with an empty FIFO and no bypass.
  - Strict in-order: responses leave in accept order.
  - resp_data and resp_id hold their last values when empty; they are zero only after reset.
- Outstanding counter (0..FIFO_DEPTH):
  - +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
  - Pop at outstanding==FIFO_DEPTH does NOT enable an accept in the same cycle: the grant uses the registered count, and the accept follows one cycle later.
- Invariant: FIFO push never happens when full. Assert in the bench; design guarantees it via credit.
- Single requester active: granted every cycle while credit remains (throughput 1/cycle).

Test Plan:
- Basic path: rst 2 cycles, requester 2 drives 0x05 for one accept in cycle t, resp_ready=1 -> resp_valid exactly in cycle t+LAT, resp_data=0x19, resp_id=2, busy back to 0 one cycle after the pop.
- Wrap-around: operand 0xF0 (STAGES=20) -> resp_data=0x04. Operand 0xEC -> 0x00.
- Round-robin fairness: all 4 req_valid held high, resp_ready=1 -> accept order 0,1,2,3,0,1 with one accept per cycle; responses arrive with ids in the same order.
- Backpressure/credit: resp_ready=0, requester 1 always valid -> exactly 8 accepts, then req_ready=0 forever, no FIFO overflow. Raise resp_ready for 1 cycle -> one pop, and the next accept occurs the following cycle.
- Simultaneous accept+pop: steady stream at outstanding=5 with resp_ready=1 -> outstanding stays 5 each cycle and the data sequence is intact.
- Reset mid-operation: 3 in flight plus 2 queued, assert rst 1 cycle -> next cycle resp_valid=0, busy=0, req_ready=0. Requester 3 request afterward -> its response is the only one seen, id=3.
